// File: rtl/op_pkg.sv
// Shared front-end types: L0 supplier FSM states and default sizing constants.
package op_pkg;

  localparam int SUPER_SCALAR_WIDTH = 4;
  localparam int L0_NUM_LINES       = 4;

  typedef enum logic [2:0] {
    LOOKUP    = 3'd0,
    MISS_REQ  = 3'd1,
    MISS_WAIT = 3'd2,
    DELIVER   = 3'd3,
    DRAIN     = 3'd4
  } l0_state_e;

endpackage

// File: rtl/l0_tag_array.sv
// Fully-associative L0 line store: combinational tag match, one read port, one fill port.
module l0_tag_array
  import op_pkg::*;
#(
  parameter int NUM_LINES  = L0_NUM_LINES,
  parameter int TAG_W      = 58,
  parameter int LINE_BYTES = 64,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TAG_W-1:0]           lookup_tag,
  output logic                       hit,
  output logic [IDX_W-1:0]           hit_idx,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic [LINE_BYTES-1:0][7:0] rd_data,
  input  logic                       we,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic [LINE_BYTES-1:0][7:0] wr_data
);

  logic [NUM_LINES-1:0]                       valid;
  logic [NUM_LINES-1:0][TAG_W-1:0]            tags;
  logic [NUM_LINES-1:0][LINE_BYTES-1:0][7:0]  data;
  logic [NUM_LINES-1:0]                       match;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_cmp
    assign match[i] = valid[i] && (tags[i] == lookup_tag);
  end

  // At most one entry can match: a line is only filled after it missed.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (match[i]) hit_idx = IDX_W'(i);
  end

  assign hit     = |match;
  assign rd_data = data[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/l0_line_supplier.sv
// Fetch-side line supplier: L0 lookup, L1 miss handling, and the valid/ready transfer to fetch.
module l0_line_supplier
  import op_pkg::*;
#(
  parameter int          CACHE_LINE_WIDTH   = 64,
  parameter int          NUM_LINES          = L0_NUM_LINES,
  parameter int          SUPER_SCALAR_WIDTH = op_pkg::SUPER_SCALAR_WIDTH,
  parameter logic [63:0] RESET_PC           = 64'h0,
  localparam int         PVW                = $clog2(SUPER_SCALAR_WIDTH + 1)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             flush_in,
  input  logic [63:0]                      flush_pc_in,
  input  logic                             fetch_ready,
  input  logic                             bp_pred_taken,
  input  logic [63:0]                      bp_pred_target,
  output logic [CACHE_LINE_WIDTH-1:0][7:0] l0_cacheline,
  output logic                             bp_l0_valid,
  output logic [63:0]                      pc,
  output logic [PVW-1:0]                   pc_valid,
  output logic [63:0]                      pred_pc,
  output logic                             l1_req_valid,
  output logic [63:0]                      l1_req_addr,
  input  logic                             l1_req_ready,
  input  logic                             l1_resp_valid,
  input  logic [CACHE_LINE_WIDTH-1:0][7:0] l1_resp_line
);

  localparam int OFF_W = $clog2(CACHE_LINE_WIDTH);
  localparam int TAG_W = 64 - OFF_W;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam logic [OFF_W:0] LINE_B = (OFF_W + 1)'(CACHE_LINE_WIDTH);
  localparam logic [OFF_W:0] SSW_B  = (OFF_W + 1)'(SUPER_SCALAR_WIDTH);

  l0_state_e   state;
  logic [63:0] pc_q;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx_q;

  logic [63:0]      pc_w;
  logic [63:0]      line_base;
  logic [OFF_W:0]   bytes_left;
  logic [OFF_W:0]   words_left;
  logic [PVW-1:0]   pc_valid_nxt;
  logic [63:0]      pred_pc_nxt;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [CACHE_LINE_WIDTH-1:0][7:0] rd_data;
  logic             fill;

  // Instruction slots are 4 bytes; the two low PC bits carry no meaning here.
  assign pc_w       = pc_q & ~64'h3;
  assign line_base  = pc_q & ~64'(CACHE_LINE_WIDTH - 1);
  assign bytes_left = LINE_B - {1'b0, pc_w[OFF_W-1:0]};
  assign words_left = bytes_left >> 2;

  assign pc_valid_nxt = (words_left >= SSW_B) ? PVW'(SUPER_SCALAR_WIDTH) : PVW'(words_left);
  assign pred_pc_nxt  = bp_pred_taken ? bp_pred_target
                                      : pc_w + {{(62 - PVW){1'b0}}, pc_valid_nxt, 2'b00};

  // Responses only count while one is outstanding; anything else is stale.
  assign fill = l1_resp_valid && (state == MISS_WAIT || state == DRAIN);

  l0_tag_array #(
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (TAG_W),
    .LINE_BYTES (CACHE_LINE_WIDTH)
  ) u_tags (
    .clk        (clk_in),
    .rst        (rst_in),
    .lookup_tag (pc_q[63:OFF_W]),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .rd_idx     (idx_q),
    .rd_data    (rd_data),
    .we         (fill),
    .wr_idx     (rr_ptr),
    .wr_tag     (l1_req_addr[63:OFF_W]),
    .wr_data    (l1_resp_line)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= LOOKUP;
      pc_q         <= RESET_PC;
      rr_ptr       <= '0;
      idx_q        <= '0;
      bp_l0_valid  <= 1'b0;
      l1_req_valid <= 1'b0;
      l1_req_addr  <= '0;
      pc           <= '0;
      pc_valid     <= '0;
      pred_pc      <= '0;
      l0_cacheline <= '0;
    end else begin
      if (fill) rr_ptr <= rr_ptr + 1'b1;

      if (flush_in) begin
        // An accepted request still owes us a response; drain it so it can't be delivered.
        pc_q         <= flush_pc_in;
        bp_l0_valid  <= 1'b0;
        l1_req_valid <= 1'b0;
        case (state)
          MISS_REQ:  state <= l1_req_ready  ? DRAIN  : LOOKUP;
          MISS_WAIT: state <= l1_resp_valid ? LOOKUP : DRAIN;
          DRAIN:     state <= l1_resp_valid ? LOOKUP : DRAIN;
          default:   state <= LOOKUP;
        endcase
      end else begin
        case (state)
          LOOKUP: begin
            if (hit) begin
              idx_q <= hit_idx;
              state <= DELIVER;
            end else begin
              l1_req_valid <= 1'b1;
              l1_req_addr  <= line_base;
              state        <= MISS_REQ;
            end
          end
          MISS_REQ: begin
            if (l1_req_ready) begin
              l1_req_valid <= 1'b0;
              state        <= MISS_WAIT;
            end
          end
          MISS_WAIT: begin
            if (l1_resp_valid) begin
              idx_q <= rr_ptr;
              state <= DELIVER;
            end
          end
          DELIVER: begin
            // First DELIVER cycle registers the transfer; later cycles hold it until taken.
            if (!bp_l0_valid) begin
              l0_cacheline <= rd_data;
              pc           <= pc_w;
              pc_valid     <= pc_valid_nxt;
              pred_pc      <= pred_pc_nxt;
              bp_l0_valid  <= 1'b1;
            end else if (fetch_ready) begin
              pc_q        <= pred_pc;
              bp_l0_valid <= 1'b0;
              state       <= LOOKUP;
            end
          end
          DRAIN: begin
            if (l1_resp_valid) state <= LOOKUP;
          end
          default: state <= LOOKUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_l0_line_supplier.sv
// Directed plus randomized bench for l0_line_supplier against a queue-based L0 model.
module tb_l0_line_supplier;
  import op_pkg::*;

  localparam int CLW = 64;
  localparam int SSW = SUPER_SCALAR_WIDTH;
  localparam int PVW = $clog2(SSW + 1);

  logic              clk_in = 1'b0;
  logic              rst_in, flush_in, fetch_ready, bp_pred_taken;
  logic              l1_req_ready, l1_resp_valid;
  logic [63:0]       flush_pc_in, bp_pred_target;
  logic [CLW-1:0][7:0] l0_cacheline, l1_resp_line;
  logic              bp_l0_valid, l1_req_valid;
  logic [63:0]       pc, pred_pc, l1_req_addr;
  logic [PVW-1:0]    pc_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  l0_line_supplier #(
    .CACHE_LINE_WIDTH (CLW),
    .NUM_LINES        (4),
    .RESET_PC         (64'h1000)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .flush_pc_in    (flush_pc_in),
    .fetch_ready    (fetch_ready),
    .bp_pred_taken  (bp_pred_taken),
    .bp_pred_target (bp_pred_target),
    .l0_cacheline   (l0_cacheline),
    .bp_l0_valid    (bp_l0_valid),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pred_pc        (pred_pc),
    .l1_req_valid   (l1_req_valid),
    .l1_req_addr    (l1_req_addr),
    .l1_req_ready   (l1_req_ready),
    .l1_resp_valid  (l1_resp_valid),
    .l1_resp_line   (l1_resp_line)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < CLW; i++)
      d[i*8 +: 8] = (8'(a[15:6]) * 8'd13 + 8'(i)) ^ {a[17:14], 4'h5};
    return d;
  endfunction

  function automatic int exp_pcv(input logic [63:0] p);
    int w;
    w = (CLW - int'(p % CLW)) / 4;
    return (w < SSW) ? w : SSW;
  endfunction

  task automatic wait_req(input logic [63:0] addr);
    int n = 0;
    do begin @(negedge clk_in); n++; end while (!l1_req_valid && n < 40);
    chk("req_seen", l1_req_valid, 1'b1);
    chk("req_addr", l1_req_addr, addr);
  endtask

  task automatic serve_miss(input logic [63:0] addr, input int lat, input int rdly);
    wait_req(addr);
    repeat (rdly) @(negedge clk_in);
    chk("req_hold", l1_req_valid, 1'b1);
    l1_req_ready = 1'b1;
    @(negedge clk_in);
    l1_req_ready = 1'b0;
    repeat (lat - 1) @(negedge clk_in);
    l1_resp_valid = 1'b1;
    l1_resp_line  = line_of(addr);
    @(negedge clk_in);
    l1_resp_valid = 1'b0;
  endtask

  task automatic take(input logic [63:0] epc, input int epcv, input logic [63:0] epred,
                      input int stall, input bit do_flush, input logic [63:0] fpc,
                      output int lat);
    int n = 0;
    bit saw_req = 1'b0;
    do begin
      @(negedge clk_in);
      n++;
      if (l1_req_valid) saw_req = 1'b1;
    end while (!bp_l0_valid && n < 40);
    lat = n;
    chk("valid", bp_l0_valid, 1'b1);
    chk("no_req", saw_req, 1'b0);
    chk("pc", pc, epc);
    chk("pc_valid", pc_valid, epcv);
    chk("pred_pc", pred_pc, epred);
    chk("line", l0_cacheline, line_of(epc & ~64'(CLW - 1)));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_in);
      chk("stall_valid", bp_l0_valid, 1'b1);
      chk("stall_pc", pc, epc);
      chk("stall_pred", pred_pc, epred);
      chk("stall_line", l0_cacheline, line_of(epc & ~64'(CLW - 1)));
    end
    if (do_flush) begin
      flush_in = 1'b1; flush_pc_in = fpc;
      @(negedge clk_in);
      flush_in = 1'b0;
      chk("flush_drop", bp_l0_valid, 1'b0);
    end else begin
      fetch_ready = 1'b1;
      @(negedge clk_in);
      fetch_ready = 1'b0;
      chk("accept_drop", bp_l0_valid, 1'b0);
    end
  endtask

  initial begin
    int lat;
    logic [63:0] mpc, line, tgt, fpc;
    logic [63:0] mq[$];
    bit hit, taken, fl;
    int pcv;

    rst_in = 1'b1; flush_in = 1'b0; flush_pc_in = '0; fetch_ready = 1'b0;
    bp_pred_taken = 1'b0; bp_pred_target = '0;
    l1_req_ready = 1'b0; l1_resp_valid = 1'b0; l1_resp_line = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_valid", bp_l0_valid, 1'b0);
    chk("rst_req", l1_req_valid, 1'b0);
    chk("rst_pcv", pc_valid, 0);
    chk("rst_pred", pred_pc, 0);
    chk("rst_addr", l1_req_addr, 0);
    rst_in = 1'b0;

    // Cold miss, then a hit in the same line steered to the line tail.
    serve_miss(64'h1000, 3, 0);
    take(64'h1000, 4, 64'h1010, 0, 0, 0, lat);
    chk("miss_lat", lat, 1);
    bp_pred_taken = 1'b1; bp_pred_target = 64'h1038;
    take(64'h1010, 4, 64'h1038, 0, 0, 0, lat);
    chk("hit_lat", lat, 2);
    bp_pred_taken = 1'b0;
    take(64'h1038, 2, 64'h1040, 0, 0, 0, lat);

    // Line-end fallthrough misses the next line; backpressure holds outputs.
    serve_miss(64'h1040, 2, 1);
    take(64'h1040, 4, 64'h1050, 5, 0, 0, lat);
    bp_pred_taken = 1'b1; bp_pred_target = 64'h2000;
    take(64'h1050, 4, 64'h2000, 0, 0, 0, lat);
    chk("hit_lat2", lat, 2);
    bp_pred_taken = 1'b0;

    // Flush while waiting on L1: response fills but is never delivered.
    wait_req(64'h2000);
    l1_req_ready = 1'b1; @(negedge clk_in); l1_req_ready = 1'b0;
    flush_in = 1'b1; flush_pc_in = 64'h3000; @(negedge clk_in); flush_in = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      chk("drain_valid", bp_l0_valid, 1'b0);
      chk("drain_req", l1_req_valid, 1'b0);
    end
    l1_resp_valid = 1'b1; l1_resp_line = line_of(64'h2000);
    @(negedge clk_in);
    l1_resp_valid = 1'b0;
    chk("drain_valid2", bp_l0_valid, 1'b0);
    serve_miss(64'h3000, 2, 0);
    bp_pred_taken = 1'b1; bp_pred_target = 64'h2000;
    take(64'h3000, 4, 64'h2000, 0, 0, 0, lat);
    bp_pred_target = 64'h4000;
    take(64'h2000, 4, 64'h4000, 0, 0, 0, lat);
    chk("drained_hit_lat", lat, 2);

    // Fifth distinct line evicts entry 0 (line 0x1000).
    serve_miss(64'h4000, 1, 0);
    bp_pred_target = 64'h1000;
    take(64'h4000, 4, 64'h1000, 0, 0, 0, lat);
    serve_miss(64'h1000, 2, 0);
    bp_pred_target = 64'h5000;
    take(64'h1000, 4, 64'h5000, 0, 0, 0, lat);

    // Async reset while waiting on L1; the late response must be dropped.
    wait_req(64'h5000);
    l1_req_ready = 1'b1; @(negedge clk_in); l1_req_ready = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("arst_valid", bp_l0_valid, 1'b0);
    chk("arst_req", l1_req_valid, 1'b0);
    chk("arst_addr", l1_req_addr, 0);
    chk("arst_pcv", pc_valid, 0);
    chk("arst_pred", pred_pc, 0);
    chk("arst_pc", pc, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    l1_resp_valid = 1'b1; l1_resp_line = line_of(64'h5000);
    @(negedge clk_in);
    l1_resp_valid = 1'b0;
    chk("late_resp_valid", bp_l0_valid, 1'b0);
    serve_miss(64'h1000, 2, 0);
    take(64'h1000, 4, 64'h5000, 0, 0, 0, lat);
    serve_miss(64'h5000, 2, 0);
    bp_pred_taken = 1'b0;
    take(64'h5000, 4, 64'h5010, 0, 0, 0, lat);

    // Randomized walk against a FIFO-replacement L0 model.
    rst_in = 1'b1; @(negedge clk_in); rst_in = 1'b0;
    mpc = 64'h1000;
    mq.delete();
    for (int it = 0; it < 40; it++) begin
      line = mpc & ~64'(CLW - 1);
      hit = 1'b0;
      foreach (mq[k]) if (mq[k] == line) hit = 1'b1;
      taken = ($urandom_range(0, 2) == 0);
      tgt = 64'h8000 + 64'($urandom_range(0, 5)) * 64 + 64'($urandom_range(0, 15)) * 4;
      bp_pred_taken = taken; bp_pred_target = tgt;
      if (!hit) begin
        serve_miss(line, $urandom_range(1, 4), $urandom_range(0, 2));
        mq.push_back(line);
        if (mq.size() > 4) void'(mq.pop_front());
      end
      pcv = exp_pcv(mpc);
      fl  = ($urandom_range(0, 5) == 0);
      fpc = 64'h8000 + 64'($urandom_range(0, 5)) * 64 + 64'($urandom_range(0, 15)) * 4;
      take(mpc, pcv, taken ? tgt : mpc + 64'(4 * pcv), $urandom_range(0, 2), fl, fpc, lat);
      chk(hit ? "rnd_hit_lat" : "rnd_miss_lat", lat, hit ? 2 : 1);
      mpc = fl ? fpc : (taken ? tgt : mpc + 64'(4 * pcv));
      bp_pred_taken = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
